// File: rtl/xmr_pipe_pkg.sv
// Shared constants and helpers for the XMR elimination pass and its
// generated write-direction drive pipelines.
package xmr_pipe_pkg;

  localparam string XMR_PORT_PREFIX = "__xmr__";
  localparam string XMR_DRIVE_SUFFIX = "_drv";

  // Wide enough to count 0..n with headroom for the n=0 case.
  function automatic int cnt_width(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/xmr_pipe_stage.sv
// One elastic register slice: loads when empty or when downstream
// takes its current content, so the ready chain gives full throughput.
module xmr_pipe_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/xmr_drive_pipe.sv
// Carries a value written through an XMR down to the target signal via
// STAGES elastic slices; the target side holds the last applied value.
module xmr_drive_pipe
  import xmr_pipe_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = cnt_width(STAGES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] src_data,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic             tgt_ready,
  output logic [WIDTH-1:0] tgt_value,
  output logic             tgt_update,
  output logic [CNT_W-1:0] inflight,
  output logic             busy
);

  logic             last_valid;
  logic [WIDTH-1:0] last_data;
  logic             accept;
  logic             apply;

  logic [WIDTH-1:0] tgt_value_q, tgt_value_d;
  logic             tgt_update_q, tgt_update_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;

  // Each slice keeps its own wires so the ready chain never loops through one vector.
  if (STAGES == 0) begin : g_direct
    assign src_ready  = tgt_ready;
    assign last_valid = src_valid;
    assign last_data  = src_data;
  end else begin : g_pipe
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             in_valid_w;
      logic [WIDTH-1:0] in_data_w;
      logic             ready_w;
      logic             out_valid_w;
      logic [WIDTH-1:0] out_data_w;
      logic             down_ready_w;

      if (k == 0) begin : g_first
        assign in_valid_w = src_valid;
        assign in_data_w  = src_data;
      end else begin : g_chain
        assign in_valid_w = g_stage[k-1].out_valid_w;
        assign in_data_w  = g_stage[k-1].out_data_w;
      end

      if (k == STAGES - 1) begin : g_tail
        assign down_ready_w = tgt_ready;
      end else begin : g_body
        assign down_ready_w = g_stage[k+1].ready_w;
      end

      xmr_pipe_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid_w),
        .in_data  (in_data_w),
        .in_ready (ready_w),
        .out_valid(out_valid_w),
        .out_data (out_data_w),
        .out_ready(down_ready_w)
      );
    end

    assign src_ready  = g_stage[0].ready_w;
    assign last_valid = g_stage[STAGES-1].out_valid_w;
    assign last_data  = g_stage[STAGES-1].out_data_w;
  end

  assign accept = src_valid && src_ready;
  assign apply  = last_valid && tgt_ready;

  always_comb begin
    tgt_value_d  = tgt_value_q;
    tgt_update_d = apply;
    inflight_d   = inflight_q;
    if (apply) begin
      tgt_value_d = last_data;
    end
    if (STAGES != 0) begin
      if (accept && !apply) begin
        inflight_d = inflight_q + CNT_W'(1);
      end else if (!accept && apply) begin
        inflight_d = inflight_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgt_value_q  <= RESET_VAL;
      tgt_update_q <= 1'b0;
      inflight_q   <= '0;
    end else begin
      tgt_value_q  <= tgt_value_d;
      tgt_update_q <= tgt_update_d;
      inflight_q   <= inflight_d;
    end
  end

  assign tgt_value  = tgt_value_q;
  assign tgt_update = tgt_update_q;
  assign inflight   = inflight_q;
  assign busy       = (inflight_q != '0);

endmodule
